// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex seven-segment driver. Shadow registers are reloaded once per frame.
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module sseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    tick_q;

    logic                    cnt_wrap, frame_end;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_en, cur_lz, blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign cnt_wrap  = (cnt_q == CNT_MAX);
    assign frame_end = cnt_wrap && (idx_q == IDX_MAX);

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // upper_zero[i]: shadow nibbles and dp bits i..NUM_DIGITS-1 are all zero
    logic [NUM_DIGITS:0] upper_zero;
    assign upper_zero[NUM_DIGITS] = 1'b1;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
        assign upper_zero[gi] = upper_zero[gi+1] & (sh_val_q[4*gi +: 4] == 4'h0) & ~sh_dp_q[gi];
        if (gi == 0) begin : g_first
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            assign lz_blank[gi] = upper_zero[gi];
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib = sh_val_q[4*i +: 4];
                cur_dp  = sh_dp_q[i];
                cur_en  = sh_en_q[i];
                cur_lz  = lz_blank[i];
            end
        end
        blank = ~cur_en | cur_lz;

        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!blank && idx_q == IW'(i)) begin
                an_d[i] = 1'b0;
            end
        end
        seg_d = blank ? 7'b1111111 : hex7(cur_nib);
        dp_d  = blank ? 1'b1 : ~cur_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_val_q <= '0;
            sh_dp_q  <= '0;
            sh_en_q  <= '0;
            an_q     <= '1;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= frame_end;
            if (frame_end) begin
                sh_val_q <= value;
                sh_dp_q  <= dp_in;
                sh_en_q  <= digit_en;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule
